// File: rtl/mem_ss_cal_seq.sv
// mem_ss_cal_seq: resets and calibrates EMIF channels one at a time with per-channel retries and timeout.
// Sticky per-channel pass/fail status is held until the next start pulse or reset.
module mem_ss_cal_seq #(
  parameter int          NUM_MEM_DEVICES  = 1,
  parameter logic [31:0] TIMEOUT_CYCLES   = 32'd1_000_000,
  parameter int          MAX_RETRIES      = 2,
  parameter int          RST_PULSE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_MEM_DEVICES-1:0] emif_cal_success,
  input  logic [NUM_MEM_DEVICES-1:0] emif_cal_fail,
  output logic [NUM_MEM_DEVICES-1:0] emif_rst_n,
  output logic [NUM_MEM_DEVICES-1:0] cal_success,
  output logic [NUM_MEM_DEVICES-1:0] cal_fail,
  output logic                       busy,
  output logic [((NUM_MEM_DEVICES > 1) ? $clog2(NUM_MEM_DEVICES) : 1)-1:0] cur_dev,
  output logic [3:0]                 retry_cnt
);
  localparam int CW = (NUM_MEM_DEVICES > 1) ? $clog2(NUM_MEM_DEVICES) : 1;
  typedef enum logic [2:0] {IDLE, ASSERT_RST, WAIT_CAL, NEXT, DONE} state_t;
  state_t                     r_state, w_nxt;
  logic [31:0]                r_timer;
  logic [CW-1:0]              r_cur_dev;
  logic [3:0]                 r_retry;
  logic [NUM_MEM_DEVICES-1:0] r_rst_n, r_succ, r_fail;
  logic                       r_busy;
  logic                       w_guard_ok, w_ok, w_bad, w_can_retry;
  // Status seen in the first few WAIT_CAL cycles may be left over from before the reset pulse.
  assign w_guard_ok  = r_timer >= 32'd4;
  assign w_ok        = w_guard_ok && emif_cal_success[r_cur_dev];
  assign w_bad       = (w_guard_ok && emif_cal_fail[r_cur_dev]) || r_timer == TIMEOUT_CYCLES - 32'd1;
  assign w_can_retry = r_retry < 4'(MAX_RETRIES);
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:       w_nxt = ASSERT_RST;
      ASSERT_RST: w_nxt = (r_timer == 32'(RST_PULSE_CYCLES - 1)) ? WAIT_CAL : ASSERT_RST;
      WAIT_CAL:   w_nxt = w_ok ? NEXT : !w_bad ? WAIT_CAL : w_can_retry ? ASSERT_RST : NEXT;
      NEXT:       w_nxt = (r_cur_dev == CW'(NUM_MEM_DEVICES - 1)) ? DONE : ASSERT_RST;
      DONE:       w_nxt = start ? IDLE : DONE;
      default:    w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_cur_dev <= '0;
      r_retry   <= '0;
      r_rst_n   <= '0;
      r_succ    <= '0;
      r_fail    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= w_nxt inside {ASSERT_RST, WAIT_CAL, NEXT};
      r_timer <= (w_nxt == r_state && w_nxt inside {ASSERT_RST, WAIT_CAL}) ? r_timer + 32'd1 : '0;
      case (r_state)
        IDLE: begin
          r_cur_dev <= '0;
          r_retry   <= '0;
        end
        ASSERT_RST: if (w_nxt == WAIT_CAL) r_rst_n[r_cur_dev] <= 1'b1;
        WAIT_CAL: begin
          if (w_ok) r_succ[r_cur_dev] <= 1'b1;
          else if (w_bad) begin
            // A failed device is held in reset whether it is retried or given up on.
            r_rst_n[r_cur_dev] <= 1'b0;
            if (w_can_retry) r_retry <= r_retry + 4'd1;
            else r_fail[r_cur_dev] <= 1'b1;
          end
        end
        NEXT: begin
          r_retry <= '0;
          if (w_nxt == ASSERT_RST) r_cur_dev <= r_cur_dev + 1'b1;
        end
        DONE: if (start) begin
          r_succ    <= '0;
          r_fail    <= '0;
          r_rst_n   <= '0;
          r_cur_dev <= '0;
        end
        default: ;
      endcase
    end
  end
  assign emif_rst_n  = r_rst_n;
  assign cal_success = r_succ;
  assign cal_fail    = r_fail;
  assign busy        = r_busy;
  assign cur_dev     = r_cur_dev;
  assign retry_cnt   = r_retry;
endmodule

// File: doc/mem_ss_cal_seq.md
MEM_SS_CAL_SEQ -- requirements
Module: mem_ss_cal_seq

Interface
REQ-001 SHALL provide parameter NUM_MEM_DEVICES, default 1: number of EMIF channels sequenced (1..8).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 32'd1_000_000: max WAIT_CAL cycles per attempt (>= 8).
REQ-003 SHALL provide parameter MAX_RETRIES, default 2: extra attempts after the first failed attempt (0..15).
REQ-004 SHALL provide parameter RST_PULSE_CYCLES, default 16: EMIF reset assertion length per attempt (>= 1).
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low, on clk.
- start  in  1  one-cycle pulse; re-runs calibration of all devices.
- emif_cal_success  in  NUM_MEM_DEVICES  per-device EMIF cal pass, clk-synchronous.
- emif_cal_fail  in  NUM_MEM_DEVICES  per-device EMIF cal fail, clk-synchronous.
- emif_rst_n  out  NUM_MEM_DEVICES  per-device EMIF reset, active-low.
- cal_success  out  NUM_MEM_DEVICES  sticky pass status, to EMIF_STATUS CSR.
- cal_fail  out  NUM_MEM_DEVICES  sticky fail status, to EMIF_STATUS CSR.
- busy  out  1  sequence in progress.
- cur_dev  out  max(1,$clog2(NUM_MEM_DEVICES))  device being calibrated.
- retry_cnt  out  4  attempts used on cur_dev minus one.

Function
REQ-006 SHALL calibrate devices strictly one at a time, index 0 upward.
REQ-007 SHALL implement FSM states IDLE, ASSERT_RST, WAIT_CAL, NEXT, DONE. All outputs SHALL be registered.
REQ-008 IDLE SHALL go to ASSERT_RST unconditionally next cycle; busy=1 from that cycle. cur_dev=0, retry_cnt=0.
REQ-009 ASSERT_RST SHALL drive emif_rst_n[cur_dev]=0 for exactly RST_PULSE_CYCLES cycles, then enter WAIT_CAL with emif_rst_n[cur_dev]=1.
REQ-010 WAIT_CAL SHALL start a 32-bit timer at 0 on entry, increment each cycle, and ignore emif_cal_* for the first 4 cycles (stale-status guard).
REQ-011 WAIT_CAL, emif_cal_success[cur_dev]=1 (after guard): set cal_success[cur_dev], go NEXT; success SHALL win over a simultaneous fail.
REQ-012 WAIT_CAL, emif_cal_fail[cur_dev]=1 or timer==TIMEOUT_CYCLES-1: if retry_cnt<MAX_RETRIES, increment retry_cnt and re-enter ASSERT_RST. Otherwise set cal_fail[cur_dev], drive emif_rst_n[cur_dev]=0 permanently for this run, go NEXT.
REQ-013 NEXT SHALL last one cycle and clear retry_cnt. If cur_dev==NUM_MEM_DEVICES-1, go DONE; else increment cur_dev and go ASSERT_RST.
REQ-014 DONE SHALL deassert busy and hold all status. start=1 in DONE SHALL go to IDLE and, in that same transition, clear cal_success, cal_fail and all emif_rst_n bits.
REQ-015 start SHALL be ignored in every state except DONE.
REQ-016 Devices not yet sequenced in the current run SHALL have emif_rst_n=0. Passed devices SHALL keep emif_rst_n=1 until the next start or reset.
REQ-017 emif_cal_* bits of devices other than cur_dev SHALL be ignored.
REQ-018 cal_success and cal_fail SHALL never both be 1 for the same device.

Reset
REQ-019 While rst_n=0, the block SHALL hold: state=IDLE, busy=0, cur_dev=0, retry_cnt=0, timer=0, emif_rst_n=all 0, cal_success=0, cal_fail=0.
REQ-020 rst_n=0 in any state SHALL abort the sequence within one cycle. The first cycle after release SHALL be IDLE, with the boot sequence following per REQ-008.

Verification (N=2, TIMEOUT_CYCLES=100, MAX_RETRIES=1, RST_PULSE_CYCLES=4)
REQ-021 Boot pass: both devices pass 10 cycles into WAIT_CAL -> emif_rst_n[0] low for 4 cycles then emif_rst_n[1] likewise; cal_success=2'b11, cal_fail=0, busy=0 in DONE.
REQ-022 Retry then pass: dev0 fails on the first attempt, passes on the second -> two reset pulses on dev0, retry_cnt=1 before NEXT; cal_success[0]=1.
REQ-023 Timeout: dev1 never reports -> fail after 2x(4+100) cycles of attempts; cal_fail=2'b10, emif_rst_n=2'b01 in DONE.
REQ-024 Corner cases: success+fail same cycle -> pass; success during the 4-cycle guard -> ignored; start while busy -> no effect.
REQ-025 Restart/reset: start in DONE -> status cleared next cycle and the sequence repeats. rst_n pulsed mid-WAIT_CAL -> all outputs at reset values, then a fresh boot sequence.
